des_crypt_unroll_param: RTL and testbench

//   Iterative DES core with a compile-time unroll factor: UNROLL Feistel rounds per clock, 16/UNROLL passes per block.

---
 rtl/des_pkg.sv | 92 +++++++++
 rtl/des_round_comb.sv | 15 +
 rtl/des_crypt_unroll_param.sv | 118 +++++++++++
 tb/tb_des_crypt_unroll_param.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// DES tables, block/half/round-key types and the combinational permutation helpers.
// Vectors are descending: DES bit n (1 = MSB) sits at index WIDTH-n.
package des_pkg;

  localparam int DES_ROUNDS = 16;

  typedef logic [63:0] block_t;
  typedef logic [31:0] half_t;
  typedef logic [47:0] rkey_t;

  typedef enum logic [1:0] {ST_IDLE, ST_ROUND, ST_DONE} des_st_e;

  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};

  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};

  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};

  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25};

  // Indexed by {row, col}: row = {b1,b6}, col = b2..b5 of each 6-bit group.
  localparam int SBOX [8][64] = '{
    '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,   0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
       4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,  15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
    '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,   3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
       0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,  13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
    '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,  13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
      13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,   1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
    '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,  13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
      10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,   3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
    '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,  14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
       4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,  11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
    '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,  10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
       9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,   4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
    '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,  13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
       1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,   6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
    '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,   1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
       7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,   2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

  function automatic block_t ip_perm(input block_t x);
    block_t o;
    for (int j = 0; j < 64; j++) o[63-j] = x[64-IP_T[j]];
    return o;
  endfunction

  function automatic block_t fp_perm(input block_t x);
    block_t o;
    for (int j = 0; j < 64; j++) o[63-j] = x[64-FP_T[j]];
    return o;
  endfunction

  function automatic rkey_t e_exp(input half_t r);
    rkey_t o;
    for (int j = 0; j < 48; j++) o[47-j] = r[32-E_T[j]];
    return o;
  endfunction

  function automatic half_t p_perm(input half_t x);
    half_t o;
    for (int j = 0; j < 32; j++) o[31-j] = x[32-P_T[j]];
    return o;
  endfunction

  function automatic half_t sbox_sub(input rkey_t x);
    half_t    o;
    logic [5:0] six;
    for (int b = 0; b < 8; b++) begin
      six = x[47-6*b -: 6];
      o[31-4*b -: 4] = 4'(SBOX[b][{six[5], six[0], six[4:1]}]);
    end
    return o;
  endfunction

  function automatic half_t f_func(input half_t r, input rkey_t k);
    return p_perm(sbox_sub(e_exp(r) ^ k));
  endfunction

endpackage

// File: rtl/des_round_comb.sv
// One combinational Feistel round: L' = R, R' = L ^ f(R, K).
module des_round_comb
  import des_pkg::*;
(
  input  half_t l,
  input  half_t r,
  input  rkey_t k,
  output half_t l_nxt,
  output half_t r_nxt
);

  assign l_nxt = r;
  assign r_nxt = l ^ f_func(r, k);

endmodule

// File: rtl/des_crypt_unroll_param.sv
// Iterative DES core, UNROLL Feistel rounds per clock, start/done/busy handshake.
// Optional decrypt support (key-order reversal at accept) via DES_CRYPT_DECRYPT_EN.
module des_crypt_unroll_param
  import des_pkg::*;
#(
  parameter int UNROLL = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         decrypt,
  input  logic [63:0]  message,
  input  logic [767:0] round_keys,
  output logic         busy,
  output logic         done,
  output logic [63:0]  result
);

  localparam int NPASS = DES_ROUNDS / UNROLL;
  localparam int CNT_W = (NPASS > 1) ? $clog2(NPASS) : 1;

  if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8 && UNROLL != 16) begin : g_bad_unroll
    $error("des_crypt_unroll_param: UNROLL must be 1, 2, 4, 8 or 16");
  end

  des_st_e          st;
  logic [CNT_W-1:0] cnt;
  half_t            l_q, r_q;
  logic [767:0]     keyreg, key_load;
  half_t            lc [UNROLL+1];
  half_t            rc [UNROLL+1];
  block_t           blk_in, blk_out;

`ifdef DES_CRYPT_DECRYPT_EN
  logic [767:0] key_rev;

  always_comb begin
    key_rev = '0;
    for (int i = 0; i < DES_ROUNDS; i++)
      key_rev[767-48*i -: 48] = round_keys[767-48*(DES_ROUNDS-1-i) -: 48];
  end

  assign key_load = decrypt ? key_rev : round_keys;
`else
  logic unused_decrypt;

  assign unused_decrypt = decrypt;
  assign key_load       = round_keys;
`endif

  assign blk_in = ip_perm(message);
  assign lc[0]  = l_q;
  assign rc[0]  = r_q;

  // Key for chain stage g is always in the top slot group; keyreg shifts up each pass.
  for (genvar g = 0; g < UNROLL; g++) begin : g_rnd
    des_round_comb u_rnd (
      .l     (lc[g]),
      .r     (rc[g]),
      .k     (keyreg[767-48*g -: 48]),
      .l_nxt (lc[g+1]),
      .r_nxt (rc[g+1])
    );
  end

  // Pre-output swap: FP is applied to {R16, L16}.
  assign blk_out = fp_perm({rc[UNROLL], lc[UNROLL]});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st     <= ST_IDLE;
      cnt    <= '0;
      l_q    <= '0;
      r_q    <= '0;
      keyreg <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      case (st)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            l_q    <= blk_in[63:32];
            r_q    <= blk_in[31:0];
            keyreg <= key_load;
            cnt    <= '0;
            busy   <= 1'b1;
            st     <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          l_q    <= lc[UNROLL];
          r_q    <= rc[UNROLL];
          keyreg <= keyreg << (48*UNROLL);
          if (cnt == CNT_W'(NPASS-1)) begin
            result <= blk_out;
            busy   <= 1'b0;
            done   <= 1'b1;
            st     <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          done <= 1'b0;
          st   <= ST_IDLE;
        end
        default: begin
          busy <= 1'b0;
          done <= 1'b0;
          st   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_des_crypt_unroll_param.sv
// Random and directed checks of des_crypt_unroll_param, one instance per legal UNROLL,
// against a textbook DES model (own tables, key schedule, inverse-IP for FP).
module tb_des_crypt_unroll_param;

  localparam int NI = 5;
`ifdef DES_CRYPT_DECRYPT_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif
  localparam logic [63:0] PT  = 64'h0123456789ABCDEF;
  localparam logic [63:0] CT  = 64'h85E813540F0AB405;
  localparam logic [63:0] KEY = 64'h133457799BBCDFF1;

  logic         clk = 1'b0, rst_n = 1'b1, start = 1'b0, decrypt = 1'b0;
  logic [63:0]  message = '0;
  logic [767:0] round_keys = '0;
  logic         busy_v [NI];
  logic         done_v [NI];
  logic [63:0]  res_v  [NI];

  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    des_crypt_unroll_param #(.UNROLL(1 << g)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .decrypt(decrypt), .message(message),
      .round_keys(round_keys), .busy(busy_v[g]), .done(done_v[g]), .result(res_v[g]));
  end

  // ---------------- reference model ----------------
  int IP_Q[$]  = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4, 62,54,46,38,30,22,14,6,
                   64,56,48,40,32,24,16,8, 57,49,41,33,25,17,9,1, 59,51,43,35,27,19,11,3,
                   61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  int E_Q[$]   = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                   16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  int P_Q[$]   = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10, 2,8,24,14,32,27,3,9,
                   19,13,30,6,22,11,4,25};
  int PC1_Q[$] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                   63,55,47,39,31,23,15, 7,62,54,46,38,30,22, 14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  int PC2_Q[$] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                   41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  int SH[16]   = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  int SB[8][4][16] = '{
    '{'{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7}, '{0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8},
      '{4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0}, '{15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13}},
    '{'{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10}, '{3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5},
      '{0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15}, '{13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9}},
    '{'{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8}, '{13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1},
      '{13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7}, '{1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12}},
    '{'{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15}, '{13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9},
      '{10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4}, '{3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14}},
    '{'{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9}, '{14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6},
      '{4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14}, '{11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3}},
    '{'{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11}, '{10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8},
      '{9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6}, '{4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13}},
    '{'{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1}, '{13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6},
      '{1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2}, '{6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12}},
    '{'{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7}, '{1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2},
      '{7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8}, '{2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}}};

  // Output is right-aligned; t lists 1-based source bit numbers of an nin-bit input.
  function automatic logic [63:0] perm(input logic [63:0] x, input int nin, input int t[$]);
    logic [63:0] o;
    o = '0;
    for (int j = 0; j < t.size(); j++) o[t.size()-1-j] = x[nin - t[j]];
    return o;
  endfunction

  function automatic logic [63:0] inv_perm(input logic [63:0] x, input int t[$]);
    logic [63:0] o;
    o = '0;
    for (int j = 0; j < 64; j++) o[64 - t[j]] = x[63 - j];
    return o;
  endfunction

  function automatic logic [767:0] key_sched(input logic [63:0] key);
    logic [63:0]  t;
    logic [27:0]  c, d;
    logic [767:0] rk;
    t = perm(key, 64, PC1_Q);
    c = t[55:28];
    d = t[27:0];
    for (int i = 0; i < 16; i++) begin
      for (int s = 0; s < SH[i]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      t = perm({8'h00, c, d}, 56, PC2_Q);
      rk[767-48*i -: 48] = t[47:0];
    end
    return rk;
  endfunction

  function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
    logic [63:0] t;
    logic [47:0] x;
    logic [5:0]  six;
    logic [31:0] so;
    t = perm({32'h0, r}, 32, E_Q);
    x = t[47:0] ^ k;
    for (int b = 0; b < 8; b++) begin
      six = x[47-6*b -: 6];
      so[31-4*b -: 4] = 4'(SB[b][{six[5], six[0]}][six[4:1]]);
    end
    t = perm({32'h0, so}, 32, P_Q);
    return t[31:0];
  endfunction

  function automatic logic [63:0] des_ref(input logic [63:0] m, input logic [767:0] rk, input bit dec);
    logic [63:0] t;
    logic [31:0] l, r, tmp;
    int k;
    t = perm(m, 64, IP_Q);
    l = t[63:32];
    r = t[31:0];
    for (int i = 0; i < 16; i++) begin
      k   = dec ? 15 - i : i;
      tmp = r;
      r   = l ^ feistel(r, rk[767-48*k -: 48]);
      l   = tmp;
    end
    return inv_perm({r, l}, IP_Q);
  endfunction

  // Handshake model per instance: ph 0 idle, 1..NPASS busy, NPASS+1 done.
  int          ph      [NI] = '{default: 0};
  logic [63:0] pend    [NI] = '{default: '0};
  logic [63:0] exp_res [NI] = '{default: '0};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int g = 0; g < NI; g++) begin
        ph[g]      <= 0;
        exp_res[g] <= '0;
      end
    end else begin
      for (int g = 0; g < NI; g++) begin
        if (ph[g] == 0) begin
          if (start) begin
            ph[g]   <= 1;
            pend[g] <= des_ref(message, round_keys, DEC_EN && decrypt);
          end
        end else if (ph[g] == (16 >> g)) begin
          ph[g]      <= ph[g] + 1;
          exp_res[g] <= pend[g];
        end else if (ph[g] == (16 >> g) + 1) begin
          ph[g] <= 0;
        end else begin
          ph[g] <= ph[g] + 1;
        end
      end
    end
  end

  task automatic chk(input string nm, input int idx, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s[%0d] got %h exp %h at %0t", nm, idx, got, exp, $time);
  endtask

  always @(negedge clk) begin
    for (int g = 0; g < NI; g++) begin
      chk("busy",   g, 64'(busy_v[g]), 64'(ph[g] >= 1 && ph[g] <= (16 >> g)));
      chk("done",   g, 64'(done_v[g]), 64'(ph[g] == (16 >> g) + 1));
      chk("result", g, res_v[g], exp_res[g]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic scramble();
    message = {$urandom, $urandom};
    decrypt = 1'($urandom);
    for (int i = 0; i < 24; i++) round_keys[32*i +: 32] = $urandom;
  endtask

  task automatic run_vec(input logic [63:0] m, input logic [767:0] k, input bit d,
                         input logic [63:0] exp, input string nm);
    int lat [NI];
    int bz  [NI];
    @(negedge clk);
    message = m; round_keys = k; decrypt = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    scramble();
    for (int g = 0; g < NI; g++) begin
      lat[g] = 0;
      bz[g]  = int'(busy_v[g]);
    end
    for (int e = 1; e <= 20; e++) begin
      @(negedge clk);
      scramble();
      for (int g = 0; g < NI; g++) begin
        if (busy_v[g]) bz[g]++;
        if (done_v[g] && lat[g] == 0) begin
          lat[g] = e;
          chk(nm, g, res_v[g], exp);
        end
      end
    end
    for (int g = 0; g < NI; g++) begin
      chk("latency_edges", g, 64'(lat[g]), 64'(16 >> g));
      chk("busy_cycles",   g, 64'(bz[g]),  64'(16 >> g));
    end
  endtask

  initial begin
    logic [767:0] ks;
    int           c3, c4, blocks, cyc;

    ks = key_sched(KEY);
    chk("model_k1",  0, ks[767 -: 48], 64'h1B02EFFC7072);
    chk("model_k16", 0, ks[47:0],      64'hCB3D8B0E17F5);
    chk("model_enc", 0, des_ref(PT, ks, 1'b0), CT);
    chk("model_dec", 0, des_ref(CT, ks, 1'b1), PT);

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      chk("reset_busy",   g, 64'(busy_v[g]), 64'd0);
      chk("reset_result", g, res_v[g], 64'd0);
    end
    rst_n = 1'b1;

    run_vec(PT, ks, 1'b0, CT, "known_enc");
    run_vec(CT, ks, 1'b1, DEC_EN ? PT : des_ref(CT, ks, 1'b0), "known_dec");

    // start held high: re-accept only from IDLE, period NPASS+2
    @(negedge clk);
    message = PT; round_keys = ks; decrypt = 1'b0; start = 1'b1;
    c3 = 0; c4 = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      c3 += int'(done_v[3]);
      c4 += int'(done_v[4]);
      scramble();
    end
    start = 1'b0;
    chk("held_done_pulses_u8",  3, 64'(c3), 64'd15);
    chk("held_done_pulses_u16", 4, 64'(c4), 64'd20);
    repeat (20) @(negedge clk);

    // abort mid-ROUND
    @(negedge clk);
    message = PT; round_keys = ks; decrypt = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int g = 0; g < NI; g++) begin
      chk("abort_busy",   g, 64'(busy_v[g]), 64'd0);
      chk("abort_done",   g, 64'(done_v[g]), 64'd0);
      chk("abort_result", g, res_v[g], 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(PT, ks, 1'b0, CT, "after_abort");

    // random blocks, keys and direction; inputs change every cycle
    blocks = 0;
    cyc    = 0;
    while (blocks < 1000 && cyc < 30000) begin
      @(negedge clk);
      cyc++;
      if (done_v[0]) blocks++;
      scramble();
      start = ($urandom_range(0, 3) != 0);
    end
    start = 1'b0;
    chk("random_blocks_done", 0, 64'(blocks >= 1000), 64'd1);
    repeat (20) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
